// File: rtl/traffic_lane.sv
// One Frogger lane: NUM_OBJ equally spaced objects on a wrap-around track with frog hit detection.
// Define LANE_STICKY_HIT_EN to add Hit_Clr and make Lane_Collision a sticky register.
module traffic_lane #(
    parameter int unsigned NUM_OBJ   = 3,
    parameter int unsigned OBJ_W     = 80,
    parameter int unsigned OBJ_H     = 40,
    parameter int unsigned SPACING   = 240,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned STEP      = 10,
    parameter int unsigned X_TOL     = 10,
    parameter int unsigned Y_TOL     = 1,
    parameter int unsigned FROG_SIDE = 40
) (
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [10:0]            Lane_Y,
    input  logic                   Direction,
    input  logic [4:0]             Speed,
    input  logic                   Enable,
    input  logic [10:0]            Frog_X,
    input  logic [10:0]            Frog_Y,
`ifdef LANE_STICKY_HIT_EN
    input  logic                   Hit_Clr,
`endif
    output logic [11*NUM_OBJ-1:0]  Obj_X,
    output logic [10:0]            Obj_Y,
    output logic [10:0]            Obj_W,
    output logic [10:0]            Obj_H,
    output logic                   Move_Strobe,
    output logic [NUM_OBJ-1:0]     Hit_Mask,
    output logic                   Lane_Collision
);

    localparam int unsigned TRACK_L = SCREEN_W + OBJ_W;

    typedef enum logic [1:0] {HOLD, WAIT, MOVE} state_t;

    state_t      state, state_n;
    logic [4:0]  wait_cnt, wait_cnt_n;
    logic        move;
    logic [10:0] pos [NUM_OBJ];

    logic [12:0] fx_l, fx_r, fy_t, fy_b, y_top, y_bot;
    logic        y_hit;

    // Wrap in 12 bits so the stored position always stays inside [0, TRACK_L)
    function automatic logic [10:0] advance(input logic [10:0] p, input logic dir);
        logic [11:0] s;
        if (dir) begin
            s = {1'b0, p} + 12'(STEP);
            if (s >= 12'(TRACK_L))
                s = s - 12'(TRACK_L);
        end else if (p < 11'(STEP)) begin
            s = {1'b0, p} + 12'(TRACK_L) - 12'(STEP);
        end else begin
            s = {1'b0, p} - 12'(STEP);
        end
        return 11'(s);
    endfunction

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        move       = 1'b0;
        if (!Enable) begin
            state_n    = HOLD;
            wait_cnt_n = '0;
        end else begin
            case (state)
                HOLD: state_n = WAIT;
                WAIT: begin
                    wait_cnt_n = wait_cnt + 5'd1;
                    if (wait_cnt >= Speed)
                        state_n = MOVE;
                end
                MOVE: begin
                    wait_cnt_n = '0;
                    state_n    = WAIT;
                    move       = 1'b1;
                end
                default: state_n = WAIT;
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= WAIT;
            wait_cnt    <= '0;
            Move_Strobe <= 1'b0;
            Obj_Y       <= Lane_Y;
            for (int unsigned i = 0; i < NUM_OBJ; i++)
                pos[i] <= 11'(i * SPACING);
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            Move_Strobe <= move;
            if (move)
                for (int unsigned i = 0; i < NUM_OBJ; i++)
                    pos[i] <= advance(pos[i], Direction);
        end
    end

    always_comb begin
        Obj_X = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++)
            Obj_X[11*i +: 11] = pos[i] - 11'(OBJ_W);
    end

    assign Obj_W = 11'(OBJ_W);
    assign Obj_H = 11'(OBJ_H);

    // Hit test in track coordinates; the wrapped segment of a straddling object is off-screen
    always_comb begin
        fx_l  = 13'(Frog_X) + 13'(OBJ_W + X_TOL);
        fx_r  = 13'(Frog_X) + 13'(OBJ_W + FROG_SIDE - X_TOL);
        fy_t  = 13'(Frog_Y) + 13'(Y_TOL);
        fy_b  = 13'(Frog_Y) + 13'(FROG_SIDE - Y_TOL);
        y_top = 13'(Obj_Y);
        y_bot = 13'(Obj_Y) + 13'(OBJ_H);
        y_hit = (fy_t >= y_top && fy_t <= y_bot) || (fy_b >= y_top && fy_b <= y_bot);
        Hit_Mask = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++)
            Hit_Mask[i] = y_hit &&
                ((fx_l >= 13'(pos[i]) && fx_l <= 13'(pos[i]) + 13'(OBJ_W)) ||
                 (fx_r >= 13'(pos[i]) && fx_r <= 13'(pos[i]) + 13'(OBJ_W)));
    end

`ifdef LANE_STICKY_HIT_EN
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            Lane_Collision <= 1'b0;
        else if (|Hit_Mask)
            Lane_Collision <= 1'b1;
        else if (Hit_Clr)
            Lane_Collision <= 1'b0;
    end
`else
    assign Lane_Collision = |Hit_Mask;
`endif

endmodule
